// File: rtl/four_bit_divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results and the divide-by-zero flag stay registered until the next accepted operation.
module four_bit_divider_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   dvd_shift, dvd_shift_n;
    logic [WIDTH-1:0]   dvs, dvs_n;
    // Partial remainder is always below the divisor, so WIDTH bits hold it;
    // the shifted/trial values carry the extra bit.
    logic [WIDTH-1:0]   rem, rem_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   quotient_n, remainder_n;
    logic               busy_n, done_n, div_by_zero_n;
    logic [WIDTH:0]     shifted, trial;
    logic               q_bit;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd_shift   <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            dvd_shift   <= dvd_shift_n;
            dvs         <= dvs_n;
            rem         <= rem_n;
            cnt         <= cnt_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            busy        <= busy_n;
            done        <= done_n;
            div_by_zero <= div_by_zero_n;
        end
    end

    // Next-state, trial subtraction and registered-output values
    always_comb begin
        state_n       = state;
        dvd_shift_n   = dvd_shift;
        dvs_n         = dvs;
        rem_n         = rem;
        cnt_n         = cnt;
        quotient_n    = quotient;
        remainder_n   = remainder;
        div_by_zero_n = div_by_zero;
        busy_n        = 1'b0;
        done_n        = 1'b0;
        shifted       = {rem, dvd_shift[WIDTH-1]};
        trial         = shifted - {1'b0, dvs};
        q_bit         = ~trial[WIDTH];

        case (state)
            IDLE: begin
                if (start) begin
                    dvd_shift_n   = dividend;
                    dvs_n         = divisor;
                    rem_n         = '0;
                    cnt_n         = '0;
                    div_by_zero_n = 1'b0;
                    if (divisor != '0) begin
                        state_n = CALC;
                        busy_n  = 1'b1;
                    end else begin
                        state_n       = DONE;
                        done_n        = 1'b1;
                        quotient_n    = '1;
                        remainder_n   = dividend;
                        div_by_zero_n = 1'b1;
                    end
                end
            end
            CALC: begin
                busy_n      = 1'b1;
                rem_n       = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                dvd_shift_n = {dvd_shift[WIDTH-2:0], q_bit};
                cnt_n       = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    state_n     = DONE;
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                    quotient_n  = dvd_shift_n;
                    remainder_n = rem_n;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
